rx_vref_cal: RTL and testbench
==============================

Name: rx_vref_cal

Overview:
- Receiver reference-voltage calibration controller for one rxdata lane.
- Sweeps the RDAC code (vref_sel) across the full range and checks deserialized words against a known training word at each code.
- Finds the longest contiguous passing window and programs vref_sel to its centre.
- Sits beside rxdata in the deserialized word-clock domain; drives rxdata.vref_sel and watches rxdata.dout.

Parameters:
- SEL_BITS, `RDAC_SEL_BITS, width of vref_sel.
- DATA_W, 2**`SERDES_STAGES, deserialized word width.
- SETTLE_CYCLES, 16, idle cycles after each code change before measuring (>=1).
- WORDS_PER_CODE, 64, words compared per code (>=1).
- ERR_THRESH, 0, a code passes if its mismatch count is <= ERR_THRESH.

Ports:
- clk  input  1  deserialized word clock; all logic on rising edge.
- rstb  input  1  asynchronous active-low reset.
- start  input  1  begin a calibration sweep; sampled only in IDLE.
- exp_word  input  DATA_W  expected training word; must be held stable while busy.
- dout  input  DATA_W  deserialized word from rxdata.
- vref_sel  output  SEL_BITS  RDAC code driven to rxdata.
- busy  output  1  high while a sweep is in progress.
- done  output  1  sticky; set at sweep end, cleared on the next accepted start.
- fail  output  1  sticky; no passing code found (or abort); cleared on the next accepted start.
- window_lo  output  SEL_BITS  first code of the best window.
- window_hi  output  SEL_BITS  last code of the best window.

Behaviour:
- Reset (async, rstb=0):
  - state IDLE.
  - vref_sel = 2**(SEL_BITS-1) (mid code).
  - busy, done, fail, window_lo and window_hi all 0.
  - Internal counters and window trackers cleared.
- IDLE:
  - start=1 at edge E: latch the current vref_sel as restore_code, clear done/fail/trackers, set code=0, drive vref_sel=0.
  - busy=1 from E+1; enter SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then enter MEASURE.
- MEASURE:
  - For WORDS_PER_CODE cycles, compare dout with exp_word each cycle.
  - A mismatch (any bit differs) increments err_cnt.
  - err_cnt saturates at ERR_THRESH+1.
  - Then enter EVAL.
- EVAL (1 cycle):
  - pass = err_cnt <= ERR_THRESH.
  - If pass: when cur_len==0, set cur_start=code; then increment cur_len.
  - If fail: close the current run.
  - Closing a run: if cur_len > best_len, copy cur_start/cur_len to best_start/best_len (strictly greater, so the earliest window wins a tie); then cur_len=0.
  - If code == 2**SEL_BITS-1: close any open run and enter FINISH.
  - Otherwise: code+1, vref_sel follows, clear err_cnt, enter SETTLE.
- FINISH (1 cycle):
  - best_len==0: vref_sel=restore_code, fail=1, window_lo=window_hi=0.
  - Otherwise:
    - vref_sel = best_start + (best_len-1)/2 (floor).
    - window_lo = best_start.
    - window_hi = best_start + best_len - 1.
  - done=1, busy=0 from the next cycle; return to IDLE.
- Latency: busy is high for 2**SEL_BITS*(SETTLE_CYCLES+WORDS_PER_CODE+1)+1 cycles.
- start while busy is ignored.
- Widths:
  - cur_len/best_len are SEL_BITS+1 bits so that a full-range window fits.
  - No code wrap-around: the sweep stops at the max code.
- Reset mid-sweep: immediate return to reset values; restore_code is not applied.

Optional Feature:
- Macro: RX_VREF_CAL_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 in any non-IDLE state: on the next edge go to IDLE, vref_sel=restore_code, busy=0, fail=1, done=1, window_lo/hi=0.
  - abort has priority over all state transitions in the same cycle.
- When undefined: no abort port; a sweep always runs to completion.

Test Plan:
All scenarios use SEL_BITS=4, DATA_W=4, SETTLE_CYCLES=4, WORDS_PER_CODE=8, ERR_THRESH=0, exp_word=4'b1010.
- Reset, then idle 10 cycles -> vref_sel=8, busy=0, done=0, fail=0, window_lo=window_hi=0.
- Model dout=exp_word for vref_sel in 5..10, else ~exp_word; pulse start -> busy high exactly 209 cycles, then done=1, fail=0, window_lo=5, window_hi=10, vref_sel=7.
- Passing codes 2..3 and 9..13 -> window 9..13, vref_sel=11. Passing codes 1..3 and 6..8 (tie) -> window 1..3, vref_sel=2.
- No passing code, vref_sel=8 before start -> fail=1, done=1, vref_sel=8. Passing 12..15 (window reaches max code) -> window_hi=15, vref_sel=13.
- ERR_THRESH=1, one mismatched word per code in 4..6 -> those codes pass, vref_sel=5. Start pulsed mid-sweep -> ignored, busy length unchanged.
- rstb low during MEASURE at code 9 -> vref_sel=8, busy=0 immediately. With RX_VREF_CAL_ABORT_EN, abort at code 3 -> vref_sel=restore_code, fail=1, done=1.

Source files
------------

// File: rtl/rx_vref_cal.sv
// rx_vref_cal: sweeps the rxdata RDAC code, finds the longest passing window and centres vref_sel.
// Optional abort input is enabled by defining RX_VREF_CAL_ABORT_EN.

`ifndef RDAC_SEL_BITS
`define RDAC_SEL_BITS 4
`endif
`ifndef SERDES_STAGES
`define SERDES_STAGES 2
`endif

module rx_vref_cal #(
    parameter int SEL_BITS       = `RDAC_SEL_BITS,
    parameter int DATA_W         = 2 ** `SERDES_STAGES,
    parameter int SETTLE_CYCLES  = 16,
    parameter int WORDS_PER_CODE = 64,
    parameter int ERR_THRESH     = 0
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                start,
`ifdef RX_VREF_CAL_ABORT_EN
    input  logic                abort,
`endif
    input  logic [DATA_W-1:0]   exp_word,
    input  logic [DATA_W-1:0]   dout,
    output logic [SEL_BITS-1:0] vref_sel,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [SEL_BITS-1:0] window_lo,
    output logic [SEL_BITS-1:0] window_hi
);

    localparam int LEN_W   = SEL_BITS + 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > WORDS_PER_CODE) ?
                             SETTLE_CYCLES : WORDS_PER_CODE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ERR_W   = $clog2(ERR_THRESH + 2);

    localparam logic [SEL_BITS-1:0] CODE_LAST = '1;
    localparam logic [SEL_BITS-1:0] CODE_MID  = {1'b1, {(SEL_BITS-1){1'b0}}};
    localparam logic [CNT_W-1:0]    SET_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    MEAS_LAST = CNT_W'(WORDS_PER_CODE - 1);
    localparam logic [ERR_W-1:0]    ERR_OK    = ERR_W'(ERR_THRESH);
    localparam logic [ERR_W-1:0]    ERR_SAT   = ERR_W'(ERR_THRESH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_EVAL,
        S_FINISH
    } state_e;

    state_e              state_q;
    logic [SEL_BITS-1:0] code_q;
    logic [SEL_BITS-1:0] restore_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ERR_W-1:0]    err_q;
    logic [SEL_BITS-1:0] cur_start_q;
    logic [LEN_W-1:0]    cur_len_q;
    logic [SEL_BITS-1:0] best_start_q;
    logic [LEN_W-1:0]    best_len_q;
    logic [SEL_BITS-1:0] vref_q;
    logic                busy_q;
    logic                done_q;
    logic                fail_q;
    logic [SEL_BITS-1:0] lo_q;
    logic [SEL_BITS-1:0] hi_q;

    logic                mismatch;
    logic                pass;
    logic                closing;
    logic                take;
    logic [LEN_W-1:0]    ev_len_d;
    logic [SEL_BITS-1:0] ev_start_d;
    logic [SEL_BITS-1:0] fin_mid;
    logic [SEL_BITS-1:0] fin_hi;

    // Run bookkeeping for the code being evaluated; a run also closes at the last code.
    always_comb begin
        mismatch   = (dout != exp_word);
        pass       = (err_q <= ERR_OK);
        ev_len_d   = pass ? (cur_len_q + LEN_W'(1)) : cur_len_q;
        ev_start_d = (pass && (cur_len_q == '0)) ? code_q : cur_start_q;
        closing    = !pass || (code_q == CODE_LAST);
        take       = closing && (ev_len_d > best_len_q);
        fin_mid    = best_start_q + SEL_BITS'((best_len_q - LEN_W'(1)) >> 1);
        fin_hi     = best_start_q + SEL_BITS'(best_len_q - LEN_W'(1));
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= S_IDLE;
            code_q       <= '0;
            restore_q    <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            vref_q       <= CODE_MID;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            lo_q         <= '0;
            hi_q         <= '0;
        end else begin
`ifdef RX_VREF_CAL_ABORT_EN
            if (abort && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                vref_q  <= restore_q;
                busy_q  <= 1'b0;
                fail_q  <= 1'b1;
                done_q  <= 1'b1;
                lo_q    <= '0;
                hi_q    <= '0;
            end else begin
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        restore_q    <= vref_q;
                        done_q       <= 1'b0;
                        fail_q       <= 1'b0;
                        code_q       <= '0;
                        vref_q       <= '0;
                        cnt_q        <= '0;
                        err_q        <= '0;
                        cur_start_q  <= '0;
                        cur_len_q    <= '0;
                        best_start_q <= '0;
                        best_len_q   <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SET_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_MEASURE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (mismatch && (err_q != ERR_SAT)) begin
                        err_q <= err_q + ERR_W'(1);
                    end
                    if (cnt_q == MEAS_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_EVAL;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_EVAL: begin
                    cur_start_q <= ev_start_d;
                    cur_len_q   <= closing ? '0 : ev_len_d;
                    // Strictly longer only, so the earliest window keeps a tie.
                    if (take) begin
                        best_start_q <= ev_start_d;
                        best_len_q   <= ev_len_d;
                    end
                    if (code_q == CODE_LAST) begin
                        state_q <= S_FINISH;
                    end else begin
                        code_q  <= code_q + SEL_BITS'(1);
                        vref_q  <= code_q + SEL_BITS'(1);
                        err_q   <= '0;
                        state_q <= S_SETTLE;
                    end
                end
                S_FINISH: begin
                    if (best_len_q == '0) begin
                        vref_q <= restore_q;
                        fail_q <= 1'b1;
                        lo_q   <= '0;
                        hi_q   <= '0;
                    end else begin
                        vref_q <= fin_mid;
                        lo_q   <= best_start_q;
                        hi_q   <= fin_hi;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
`ifdef RX_VREF_CAL_ABORT_EN
            end
`endif
        end
    end

    assign vref_sel  = vref_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign window_lo = lo_q;
    assign window_hi = hi_q;

endmodule

// File: tb/tb_rx_vref_cal.sv
// tb_rx_vref_cal: randomized sweeps of two rx_vref_cal instances (ERR_THRESH 0 and 1)
// checked every cycle against a window-search model, plus literal expectations.

module tb_rx_vref_cal;

    localparam int S   = 4;
    localparam int W   = 8;
    localparam int P   = S + W + 1;
    localparam int FIN = 16 * P;

    logic       clk = 1'b0;
    logic       rstb = 1'b1;
    logic       start = 1'b0;
    logic [3:0] exp_word = 4'b1010;
    logic [3:0] dout = 4'd0;
`ifdef RX_VREF_CAL_ABORT_EN
    logic       abort = 1'b0;
`endif

    logic [3:0] vref [2];
    logic [3:0] lo [2];
    logic [3:0] hi [2];
    logic       busy [2];
    logic       done [2];
    logic       fail [2];

    int n_chk = 0;
    int n_fail = 0;

    // per-code mask of which measured words are corrupted
    logic [7:0] mm [16];

    int         k = 0;
    bit         m_active = 0;
    bit         m_busy = 0;
    logic [3:0] m_vref [2];
    logic [3:0] m_lo [2];
    logic [3:0] m_hi [2];
    logic [3:0] m_restore [2];
    bit         m_done [2];
    bit         m_fail [2];
    logic [3:0] r_vref [2];
    logic [3:0] r_lo [2];
    logic [3:0] r_hi [2];
    bit         r_fail [2];

    always #5 clk = ~clk;

    rx_vref_cal #(
        .SEL_BITS(4), .DATA_W(4), .SETTLE_CYCLES(S),
        .WORDS_PER_CODE(W), .ERR_THRESH(0)
    ) dut0 (
        .clk(clk), .rstb(rstb), .start(start),
`ifdef RX_VREF_CAL_ABORT_EN
        .abort(abort),
`endif
        .exp_word(exp_word), .dout(dout),
        .vref_sel(vref[0]), .busy(busy[0]), .done(done[0]),
        .fail(fail[0]), .window_lo(lo[0]), .window_hi(hi[0])
    );

    rx_vref_cal #(
        .SEL_BITS(4), .DATA_W(4), .SETTLE_CYCLES(S),
        .WORDS_PER_CODE(W), .ERR_THRESH(1)
    ) dut1 (
        .clk(clk), .rstb(rstb), .start(start),
`ifdef RX_VREF_CAL_ABORT_EN
        .abort(abort),
`endif
        .exp_word(exp_word), .dout(dout),
        .vref_sel(vref[1]), .busy(busy[1]), .done(done[1]),
        .fail(fail[1]), .window_lo(lo[1]), .window_hi(hi[1])
    );

    task automatic chk(input string nm, input int d,
                       input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0d expected %0d at %0t",
                     d, nm, act, expv, $time);
        end
    endtask

    // Brute-force search over all code ranges; earliest longest wins.
    function automatic void predict(input int thr, input logic [3:0] restore,
                                    output logic [3:0] v, output logic [3:0] l,
                                    output logic [3:0] h, output bit f);
        int blen;
        int bst;
        blen = 0;
        bst  = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = a; b < 16; b++) begin
                bit ok;
                ok = 1;
                for (int c = a; c <= b; c++)
                    if ($countones(mm[c]) > thr) ok = 0;
                if (ok && (b - a + 1) > blen) begin
                    blen = b - a + 1;
                    bst  = a;
                end
            end
        end
        if (blen == 0) begin
            v = restore; l = 4'd0; h = 4'd0; f = 1;
        end else begin
            v = 4'(bst + (blen - 1) / 2);
            l = 4'(bst);
            h = 4'(bst + blen - 1);
            f = 0;
        end
    endfunction

    // Timeline model: each code takes P cycles, busy spans FIN+1 cycles.
    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_active <= 0;
            m_busy   <= 0;
            k        <= 0;
            for (int d = 0; d < 2; d++) begin
                m_vref[d] <= 4'd8;
                m_done[d] <= 0;
                m_fail[d] <= 0;
                m_lo[d]   <= 4'd0;
                m_hi[d]   <= 4'd0;
            end
        end else if (m_active) begin
`ifdef RX_VREF_CAL_ABORT_EN
            if (abort) begin
                m_active <= 0;
                m_busy   <= 0;
                for (int d = 0; d < 2; d++) begin
                    m_vref[d] <= m_restore[d];
                    m_fail[d] <= 1;
                    m_done[d] <= 1;
                    m_lo[d]   <= 4'd0;
                    m_hi[d]   <= 4'd0;
                end
            end else
`endif
            if (k >= FIN) begin
                m_active <= 0;
                m_busy   <= 0;
                for (int d = 0; d < 2; d++) begin
                    m_vref[d] <= r_vref[d];
                    m_lo[d]   <= r_lo[d];
                    m_hi[d]   <= r_hi[d];
                    m_fail[d] <= r_fail[d];
                    m_done[d] <= 1;
                end
            end else begin
                k <= k + 1;
                for (int d = 0; d < 2; d++)
                    m_vref[d] <= ((k + 1) / P > 15) ? 4'd15 : 4'((k + 1) / P);
            end
        end else if (start) begin
            k        <= 0;
            m_active <= 1;
            m_busy   <= 1;
            for (int d = 0; d < 2; d++) begin
                m_restore[d] <= m_vref[d];
                m_done[d]    <= 0;
                m_fail[d]    <= 0;
                m_vref[d]    <= 4'd0;
            end
        end
    end

    // rxdata stand-in: corrupted words only where the mask says so, noise elsewhere.
    always @(negedge clk) begin
        int n;
        int c;
        int pos;
        n   = k + 1;
        c   = n / P;
        pos = n % P;
        if (m_active && c < 16 && pos >= S + 1 && pos <= S + W) begin
            if (mm[c][pos-S-1]) dout = exp_word ^ 4'($urandom_range(1, 15));
            else dout = exp_word;
        end else begin
            dout = 4'($urandom);
        end
    end

    always @(negedge clk) begin
        if (rstb) begin
            for (int d = 0; d < 2; d++) begin
                chk("busy", d, busy[d], m_busy);
                chk("vref_sel", d, vref[d], m_vref[d]);
                chk("done", d, done[d], m_done[d]);
                chk("fail", d, fail[d], m_fail[d]);
                if (!m_busy) begin
                    chk("window_lo", d, lo[d], m_lo[d]);
                    chk("window_hi", d, hi[d], m_hi[d]);
                end
            end
        end
    end

    task automatic lit(input int d, input int v, input int l, input int h,
                       input int dn, input int f);
        chk("lit_vref", d, vref[d], v);
        chk("lit_lo", d, lo[d], l);
        chk("lit_hi", d, hi[d], h);
        chk("lit_done", d, done[d], dn);
        chk("lit_fail", d, fail[d], f);
    endtask

    task automatic set_win(input int a0, input int b0, input int a1, input int b1);
        for (int c = 0; c < 16; c++)
            mm[c] = ((c >= a0 && c <= b0) || (c >= a1 && c <= b1)) ? 8'h00 : 8'hFF;
    endtask

    task automatic kick();
        for (int d = 0; d < 2; d++)
            predict(d, m_vref[d], r_vref[d], r_lo[d], r_hi[d], r_fail[d]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sweep(input int ign_at);
        int blen;
        kick();
        blen = 0;
        while (busy[0] && blen < 400) begin
            blen++;
            start = (blen == ign_at);
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_len", 0, blen, 209);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rstb = 1'b0;
        repeat (2) @(negedge clk);
        #2 rstb = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        set_win(-1, -1, -1, -1);
        #1 rstb = 1'b0;
        repeat (3) @(negedge clk);
        #2 rstb = 1'b1;
        repeat (10) @(negedge clk);
        lit(0, 8, 0, 0, 0, 0);
        lit(1, 8, 0, 0, 0, 0);
        chk("lit_busy", 0, busy[0], 0);

        set_win(5, 10, -1, -1);
        sweep(0);
        lit(0, 7, 5, 10, 1, 0);
        lit(1, 7, 5, 10, 1, 0);

        set_win(2, 3, 9, 13);
        sweep(60);
        lit(0, 11, 9, 13, 1, 0);

        set_win(1, 3, 6, 8);
        sweep(0);
        lit(0, 2, 1, 3, 1, 0);

        do_reset();
        set_win(-1, -1, -1, -1);
        sweep(0);
        lit(0, 8, 0, 0, 1, 1);
        lit(1, 8, 0, 0, 1, 1);

        set_win(12, 15, -1, -1);
        sweep(0);
        lit(0, 13, 12, 15, 1, 0);

        set_win(-1, -1, -1, -1);
        for (int c = 4; c <= 6; c++) mm[c] = 8'h10;
        sweep(100);
        lit(1, 5, 4, 6, 1, 0);
        lit(0, 13, 0, 0, 1, 1);

        repeat (6) begin
            exp_word = 4'($urandom);
            for (int c = 0; c < 16; c++) begin
                case ($urandom_range(0, 3))
                    0: mm[c] = 8'h00;
                    1: mm[c] = 8'h01 << $urandom_range(0, 7);
                    2: mm[c] = 8'hFF;
                    default: mm[c] = 8'($urandom);
                endcase
            end
            sweep(($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 200)) : 0);
        end

        do_reset();
        exp_word = 4'b1010;
        set_win(3, 5, -1, -1);
        kick();
        t = 0;
        while (!(m_active && k == 9 * P + S + 3) && t < 500) begin
            t++;
            @(negedge clk);
        end
        chk("mid_vref", 0, vref[0], 9);
        #2 rstb = 1'b0;
        #1;
        chk("rst_vref", 0, vref[0], 8);
        chk("rst_busy", 0, busy[0], 0);
        chk("rst_vref", 1, vref[1], 8);
        repeat (2) @(negedge clk);
        #2 rstb = 1'b1;
        repeat (3) @(negedge clk);
        lit(0, 8, 0, 0, 0, 0);

`ifdef RX_VREF_CAL_ABORT_EN
        set_win(6, 9, -1, -1);
        kick();
        t = 0;
        while (!(m_active && k == 3 * P + 2) && t < 500) begin
            t++;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        lit(0, 8, 0, 0, 1, 1);
        chk("abort_busy", 0, busy[0], 0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
